// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state encoding, key-code constants and the row/column layout lookup.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Column 0 is the leftmost key of each row.
   function automatic logic [3:0] layout_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = KEY_1;
         4'b00_01: code = KEY_2;
         4'b00_10: code = KEY_3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = KEY_4;
         4'b01_01: code = KEY_5;
         4'b01_10: code = KEY_6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = KEY_7;
         4'b10_01: code = KEY_8;
         4'b10_10: code = KEY_9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = KEY_0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines, key-code output strobe and FSM debug state.
interface keypad_scanner_if;
   import keypad_pkg::*;

   // valid_o is a one-cycle strobe with no back-pressure: code_o is valid in that
   // cycle and stays stable until the next strobe; the consumer must take it then.
   logic [3:0] row_i;
   logic [3:0] col_o;
   logic [3:0] code_o;
   logic       valid_o;
   logic       held_o;
   state_t     dbg_state;

   modport slave  (input row_i, output col_o, code_o, valid_o, held_o, dbg_state);
   modport master (output row_i, input col_o, code_o, valid_o, held_o, dbg_state);

endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: SCAN_DIV prescaler, one-cycle tick strobe every SCAN_DIV clocks.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || tick) cnt <= '0;
      else             cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces presses/releases and strobes one code per press.
// Auto-repeat of a held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DB_CNT       = 4,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic            clk,
   input  logic            rst,
   keypad_scanner_if.slave bus
);
   localparam int CW = $clog2(DB_CNT + 1);

   logic [3:0]    row_s1, row_s2;
   logic          tick;
   logic          samp_ok;
   logic [1:0]    samp_row;
   state_t        state, state_n;
   logic [1:0]    col_idx, col_idx_n, lat_row, lat_row_n;
   logic [CW-1:0] db_cnt, db_cnt_n, rel_cnt, rel_cnt_n;
   logic [3:0]    code, code_n;
   logic          valid, valid_n, held, held_n;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(REP_MAX + 1);
   logic [RW-1:0] rep_cnt, rep_cnt_n;
   logic          rep_first, rep_first_n;
`else
   logic unused_rep;
   assign unused_rep = (REPEAT_DELAY + REPEAT_RATE) != 0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= bus.row_i;
         row_s2 <= row_s1;
      end
   end

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Only a single low row is a usable sample; ghosting/multi-press reads as no key.
   always_comb begin
      samp_ok  = 1'b1;
      samp_row = 2'd0;
      case (row_s2)
         4'b1110: samp_row = 2'd0;
         4'b1101: samp_row = 2'd1;
         4'b1011: samp_row = 2'd2;
         4'b0111: samp_row = 2'd3;
         default: samp_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_n   = state;
      col_idx_n = col_idx;
      lat_row_n = lat_row;
      db_cnt_n  = db_cnt;
      rel_cnt_n = rel_cnt;
      code_n    = code;
      held_n    = held;
      valid_n   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_n   = rep_cnt;
      rep_first_n = rep_first;
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (samp_ok) begin
                  lat_row_n = samp_row;
                  db_cnt_n  = CW'(1);
                  rel_cnt_n = '0;
                  state_n   = DEBOUNCE;
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (samp_ok && samp_row == lat_row) begin
                  if (int'(db_cnt) + 1 >= DB_CNT) begin
                     db_cnt_n = CW'(DB_CNT);
                     state_n  = PRESSED;
                     code_n   = layout_code(lat_row, col_idx);
                     valid_n  = 1'b1;
                     held_n   = 1'b1;
                  end else begin
                     db_cnt_n = db_cnt + CW'(1);
                  end
               end else begin
                  db_cnt_n  = '0;
                  state_n   = SCAN;
                  col_idx_n = col_idx + 2'd1;
               end
            end
            PRESSED: begin
               // Latched row still low keeps the press alive, whatever else is down.
               if (!row_s2[lat_row]) begin
                  rel_cnt_n = '0;
               end else if (int'(rel_cnt) + 1 >= DB_CNT) begin
                  rel_cnt_n = '0;
                  db_cnt_n  = '0;
                  held_n    = 1'b0;
                  state_n   = SCAN;
                  col_idx_n = col_idx + 2'd1;
               end else begin
                  rel_cnt_n = rel_cnt + CW'(1);
               end
            end
            default: state_n = SCAN;
         endcase
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      if (tick && state == PRESSED && state_n == PRESSED) begin
         if (!rep_first && int'(rep_cnt) + 1 >= REPEAT_DELAY) begin
            valid_n     = 1'b1;
            rep_cnt_n   = '0;
            rep_first_n = 1'b1;
         end else if (rep_first && int'(rep_cnt) + 1 >= REPEAT_RATE) begin
            valid_n   = 1'b1;
            rep_cnt_n = '0;
         end else begin
            rep_cnt_n = rep_cnt + RW'(1);
         end
      end else if (state_n != PRESSED) begin
         rep_cnt_n   = '0;
         rep_first_n = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SCAN;
         col_idx <= 2'd0;
         lat_row <= 2'd0;
         db_cnt  <= '0;
         rel_cnt <= '0;
         code    <= 4'h0;
         valid   <= 1'b0;
         held    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt   <= '0;
         rep_first <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         col_idx <= col_idx_n;
         lat_row <= lat_row_n;
         db_cnt  <= db_cnt_n;
         rel_cnt <= rel_cnt_n;
         code    <= code_n;
         valid   <= valid_n;
         held    <= held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt   <= rep_cnt_n;
         rep_first <= rep_first_n;
`endif
      end
   end

   assign bus.col_o     = ~(4'b0001 << col_idx);
   assign bus.code_o    = code;
   assign bus.valid_o   = valid;
   assign bus.held_o    = held;
   assign bus.dbg_state = state;

endmodule
